// File: rtl/axi_ar_arbiter.sv
// Round-robin arbiter for the shared AXI read-address channel.
// Optional read-data watchdog enabled with `define AR_TIMEOUT_EN.
module axi_ar_arbiter #(
    parameter int NUM_M       = 3,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 1024,
    localparam int IW         = $clog2(NUM_M)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_arvalid_i,
    input  logic [NUM_M*ADDR_W-1:0] m_araddr_i,
    input  logic [NUM_M*LEN_W-1:0]  m_arlen_i,
    output logic [NUM_M-1:0]        m_arready_o,
    output logic                    s_arvalid_o,
    output logic [ADDR_W-1:0]       s_araddr_o,
    output logic [LEN_W-1:0]        s_arlen_o,
    input  logic                    s_arready_i,
    input  logic                    s_rvalid_i,
    input  logic                    s_rready_i,
    input  logic                    s_rlast_i,
    output logic [IW-1:0]           grant_idx_o,
    output logic                    busy_o,
    output logic                    timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;

    logic [IW-1:0]       win_idx;
    logic                win_vld;
    logic [IW-1:0]       ptr_next;
    logic                r_beat;
    logic                r_done;
    logic                to_fire;

    assign r_beat = s_rvalid_i & s_rready_i;
    assign r_done = r_beat & s_rlast_i;

    assign ptr_next = (grant_q == IW'(NUM_M - 1)) ? '0 : grant_q + 1'b1;

    // Winner is the valid master at the smallest rotational distance from rr_ptr.
    always_comb begin
        int best_d;
        int d;
        win_idx = '0;
        win_vld = 1'b0;
        best_d  = NUM_M;
        d       = 0;
        for (int j = 0; j < NUM_M; j++) begin
            if (m_arvalid_i[j]) begin
                d = j - int'(rr_ptr_q);
                if (d < 0) begin
                    d = d + NUM_M;
                end
                if (d < best_d) begin
                    best_d  = d;
                    win_idx = IW'(j);
                    win_vld = 1'b1;
                end
            end
        end
    end

`ifdef AR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign to_fire = (state_q == S_DATA) && (cnt_q == CW'(TIMEOUT_CYC));

    always_comb begin
        cnt_d = '0;
        if (state_q == S_DATA && !to_fire && !r_beat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = to_fire & ~rst;
`else
    assign to_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        len_d       = len_q;
        m_arready_o = '0;
        s_arvalid_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld && !rst) begin
                    for (int k = 0; k < NUM_M; k++) begin
                        m_arready_o[k] = (IW'(k) == win_idx);
                    end
                    grant_d = win_idx;
                    addr_d  = m_araddr_i[int'(win_idx)*ADDR_W +: ADDR_W];
                    len_d   = m_arlen_i[int'(win_idx)*LEN_W +: LEN_W];
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                s_arvalid_o = ~rst;
                if (s_arready_i) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Normal completion and watchdog expiry release the grant alike.
                if (r_done || to_fire) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = ptr_next;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
        end
    end

    assign s_araddr_o  = addr_q;
    assign s_arlen_o   = len_q;
    assign grant_idx_o = grant_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Self-checking bench for axi_ar_arbiter: directed scenarios plus random
// bursts checked against a transaction-level round-robin model.
module tb_axi_ar_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int LW = 4;
    localparam int IW = 2;
`ifdef AR_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_arvalid_i = '0;
    logic [N*AW-1:0] m_araddr_i = '0;
    logic [N*LW-1:0] m_arlen_i = '0;
    logic [N-1:0]    m_arready_o;
    logic            s_arvalid_o;
    logic [AW-1:0]   s_araddr_o;
    logic [LW-1:0]   s_arlen_o;
    logic            s_arready_i = 1'b0;
    logic            s_rvalid_i = 1'b0;
    logic            s_rready_i = 1'b0;
    logic            s_rlast_i = 1'b0;
    logic [IW-1:0]   grant_idx_o;
    logic            busy_o;
    logic            timeout_o;

    axi_ar_arbiter #(
        .NUM_M(N), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_arvalid_i(m_arvalid_i), .m_araddr_i(m_araddr_i),
        .m_arlen_i(m_arlen_i), .m_arready_o(m_arready_o),
        .s_arvalid_o(s_arvalid_o), .s_araddr_o(s_araddr_o),
        .s_arlen_o(s_arlen_o), .s_arready_i(s_arready_i),
        .s_rvalid_i(s_rvalid_i), .s_rready_i(s_rready_i),
        .s_rlast_i(s_rlast_i), .grant_idx_o(grant_idx_o),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int            errs = 0;
    int            checks = 0;
    int            ptr = 0;
    bit            pend [N];
    logic [AW-1:0] paddr [N];
    logic [LW-1:0] plen [N];
    int            w;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first pending master scanning from ptr upward.
    function automatic int pick();
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (pend[k]) return k;
        end
        return -1;
    endfunction

    task automatic newreq(input int k);
        pend[k]  = 1'b1;
        paddr[k] = $urandom;
        plen[k]  = LW'($urandom_range(0, 15));
    endtask

    task automatic add_reqs(input bit force_one);
        bit any;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 3) == 0) newreq(k);
            any |= pend[k];
        end
        if (force_one && !any) newreq($urandom_range(0, N - 1));
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            m_arvalid_i[k] = pend[k];
            m_araddr_i[k*AW +: AW] = pend[k] ? paddr[k] : $urandom;
            m_arlen_i[k*LW +: LW]  = pend[k] ? plen[k] : LW'($urandom);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_ready"}, 64'(m_arready_o), 64'(0));
        chk({tag, "_arvalid"}, 64'(s_arvalid_o), 64'(0));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_timeout"}, 64'(timeout_o), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_arvalid_i = '0;
        s_arready_i = 1'b0;
        s_rvalid_i = 1'b0;
        @(negedge clk);
        #1;
        idle_chk("rst");
        chk("rst_grant", 64'(grant_idx_o), 64'(0));
        chk("rst_addr", 64'(s_araddr_o), 64'(0));
        chk("rst_len", 64'(s_arlen_o), 64'(0));
        rst = 1'b0;
        ptr = 0;
    endtask

    // One complete burst: grant, address phase with stall, then R beats.
    task automatic burst(input int stall, input bit rnd, input int late_m,
                         output int win);
        logic [AW-1:0] ea;
        logic [LW-1:0] el;
        int beats;
        int st;
        win = -1;
        ea = '0;
        el = '0;
        for (int t = 0; t < 40 && win < 0; t++) begin
            @(negedge clk);
            if (rnd) add_reqs(1'b1);
            drive();
            s_arready_i = 1'b0;
            s_rvalid_i = 1'b0;
            s_rready_i = 1'b0;
            s_rlast_i = 1'b0;
            #1;
            win = pick();
            if (win < 0) begin
                chk("idle_ready", 64'(m_arready_o), 64'(0));
            end else begin
                chk("grant_onehot", 64'(m_arready_o), 64'(1) << win);
                chk("idle_busy", 64'(busy_o), 64'(0));
                ea = paddr[win];
                el = plen[win];
            end
        end
        if (win < 0) return;
        pend[win] = 1'b0;
        st = (stall < 0) ? $urandom_range(0, 3) : stall;
        for (int c = 0; c <= st; c++) begin
            @(negedge clk);
            if (rnd) add_reqs(1'b0);
            drive();
            s_arready_i = (c == st);
            s_rvalid_i = 1'($urandom);
            s_rready_i = 1'($urandom);
            s_rlast_i = 1'($urandom);
            #1;
            chk("addr_arvalid", 64'(s_arvalid_o), 64'(1));
            chk("addr_araddr", 64'(s_araddr_o), 64'(ea));
            chk("addr_arlen", 64'(s_arlen_o), 64'(el));
            chk("addr_grant", 64'(grant_idx_o), 64'(win));
            chk("addr_ready", 64'(m_arready_o), 64'(0));
            chk("addr_busy", 64'(busy_o), 64'(1));
        end
        beats = 0;
        for (int cyc = 0; cyc < 300 && beats <= int'(el); cyc++) begin
            @(negedge clk);
            if (rnd) add_reqs(1'b0);
            if (late_m >= 0 && cyc == 1 && !pend[late_m]) newreq(late_m);
            drive();
            s_arready_i = 1'b0;
            s_rvalid_i = ($urandom_range(0, 3) != 0);
            s_rready_i = ($urandom_range(0, 3) != 0);
            s_rlast_i = s_rvalid_i && (beats == int'(el));
            #1;
            chk("data_arvalid", 64'(s_arvalid_o), 64'(0));
            chk("data_ready", 64'(m_arready_o), 64'(0));
            chk("data_busy", 64'(busy_o), 64'(1));
            chk("data_grant", 64'(grant_idx_o), 64'(win));
            if (s_rvalid_i && s_rready_i) beats++;
        end
        if (beats <= int'(el)) chk("beat_budget", 64'(beats), 64'(el) + 1);
        ptr = (win + 1) % N;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            paddr[k] = '0;
            plen[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            idle_chk("idle");
            chk("idle_grant", 64'(grant_idx_o), 64'(0));
        end

        pend[1] = 1'b1;
        paddr[1] = 32'h0001_0040;
        plen[1] = 4'd3;
        burst(4, 1'b0, -1, w);
        chk("single_winner", 64'(w), 64'(1));

        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < N; k++) if (!pend[k]) newreq(k);
            burst(-1, 1'b0, -1, w);
        end

        do_reset();
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < N; k++) if (!pend[k]) newreq(k);
            burst(-1, 1'b0, -1, w);
        end

        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        newreq(0);
        burst(-1, 1'b0, 2, w);
        burst(-1, 1'b0, -1, w);
        chk("late_winner", 64'(w), 64'(2));

        newreq(1);
        @(negedge clk);
        drive();
        #1;
        w = pick();
        chk("mid_grant", 64'(m_arready_o), 64'(1) << w);
        pend[w] = 1'b0;
        @(negedge clk);
        drive();
        #1;
        chk("mid_arvalid", 64'(s_arvalid_o), 64'(1));
        newreq(0);
        newreq(2);
        @(negedge clk);
        rst = 1'b1;
        drive();
        #1;
        chk("mid_rst_ready", 64'(m_arready_o), 64'(0));
        @(negedge clk);
        m_arvalid_i = '0;
        #1;
        idle_chk("mid_rst");
        chk("mid_rst_grant", 64'(grant_idx_o), 64'(0));
        chk("mid_rst_addr", 64'(s_araddr_o), 64'(0));
        rst = 1'b0;
        ptr = 0;
        burst(-1, 1'b0, -1, w);
        chk("post_rst_winner", 64'(w), 64'(0));

        for (int b = 0; b < 30; b++) burst(-1, 1'b1, -1, w);

`ifdef AR_TIMEOUT_EN
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        newreq(0);
        @(negedge clk);
        drive();
        s_rvalid_i = 1'b0;
        s_rready_i = 1'b0;
        s_rlast_i = 1'b0;
        #1;
        w = pick();
        chk("to_grant", 64'(m_arready_o), 64'(1) << w);
        pend[w] = 1'b0;
        @(negedge clk);
        drive();
        s_arready_i = 1'b1;
        @(negedge clk);
        s_arready_i = 1'b0;
        for (int j = 0; j <= TO; j++) begin
            #1;
            chk("to_pulse", 64'(timeout_o), 64'(j == TO));
            chk("to_busy", 64'(busy_o), 64'(1));
            @(negedge clk);
        end
        #1;
        chk("to_after", 64'(timeout_o), 64'(0));
        chk("to_idle", 64'(busy_o), 64'(0));
        ptr = (w + 1) % N;
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/axi_ar_arbiter.md
Name: axi_ar_arbiter

Overview:
- Round-robin arbiter for the AXI read-address (AR) channel, shared by NUM_M bus masters (CPU instruction fetch, CPU data, DMA).
- Captures the winning master's AR request into registers and presents it to the downstream slave path, where the address decoder routes it.
- Holds the grant until the final read-data beat completes, so only one read burst is in flight system-wide.
- Sits between the master-side AR ports and the slave-side AR/R mux of the AXI interconnect.

Parameters:
- NUM_M, 3, number of requesting masters (2..8)
- ADDR_W, 32, address width
- LEN_W, 4, burst-length field width (ARLEN)
- TIMEOUT_CYC, 1024, read-data watchdog limit in cycles; used only with AR_TIMEOUT_EN

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- m_arvalid_i  in  NUM_M  per-master AR valid
- m_araddr_i  in  NUM_M*ADDR_W  per-master address, master k at bits [k*ADDR_W +: ADDR_W]
- m_arlen_i  in  NUM_M*LEN_W  per-master burst length, same packing
- m_arready_o  out  NUM_M  per-master AR ready, one-hot or zero
- s_arvalid_o  out  1  AR valid toward the slave side
- s_araddr_o  out  ADDR_W  registered address
- s_arlen_o  out  LEN_W  registered length
- s_arready_i  in  1  AR ready from the selected slave
- s_rvalid_i  in  1  R valid of the active burst
- s_rready_i  in  1  R ready of the active burst
- s_rlast_i  in  1  R last of the active burst
- grant_idx_o  out  $clog2(NUM_M)  owner index for R routing back to the master
- busy_o  out  1  1 whenever the state is not IDLE
- timeout_o  out  1  watchdog pulse (tied 0 without the optional feature)

Behaviour:
- State machine: IDLE, ADDR, DATA. Reset and every rst cycle, including mid-burst: state=IDLE, rr_ptr=0, grant_idx_o=0, s_araddr_o=0, s_arlen_o=0; all outputs deasserted.
- IDLE:
  - Winner = first k with m_arvalid_i[k]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_M.
  - If any valid: m_arready_o[winner]=1 combinationally that same cycle. Capture addr, len and winner into registers. Next state ADDR.
  - If no valid: m_arready_o=0, stay in IDLE.
- ADDR:
  - s_arvalid_o=1. Address, length and index stay stable until s_arready_i=1, then go to DATA.
  - Request-to-s_arvalid latency is exactly 1 cycle after the master handshake.
  - R signals are ignored in ADDR.
- DATA:
  - s_arvalid_o=0; m_arready_o=0 for all masters.
  - On s_rvalid_i & s_rready_i & s_rlast_i: go to IDLE and set rr_ptr=(grant_idx_o+1) mod NUM_M.
  - A new grant is possible in the IDLE cycle immediately after rlast.
- m_arready_o is 0 for all masters in ADDR and DATA. Requests arriving then wait and are not lost.
- grant_idx_o holds its value through IDLE until the next capture.
- Pointer wrap: index NUM_M-1 wraps to 0.
- With only one master requesting, it wins every time regardless of rr_ptr.
- A master deasserting valid after its handshake has no effect; the captured data is used.

Optional Feature:
- Macro AR_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to DATA and on every R beat (s_rvalid_i & s_rready_i), and increments otherwise in DATA.
  - On reaching TIMEOUT_CYC: timeout_o=1 for one cycle, state goes to IDLE, and rr_ptr advances as for a normal rlast.
  - The counter resets to 0 on rst.
- Not defined: no counter is built, timeout_o is tied 0, and DATA exits only on rlast.

Test Plan:
- Reset then idle: all m_arvalid_i=0 for 10 cycles -> m_arready_o=0, s_arvalid_o=0, busy_o=0, grant_idx_o=0.
- Single request: master1 valid, addr 0x0001_0040, len 3 -> m_arready_o=3'b010 that cycle. Next cycle s_arvalid_o=1, s_araddr_o=0x0001_0040, s_arlen_o=3. Hold s_arready_i=0 for 4 cycles -> outputs stable. 4 R beats with rlast on the 4th -> IDLE, rr_ptr=2.
- Fairness: all 3 masters valid continuously for 3 bursts from reset -> grant order 0, 1, 2, then 0 again.
- Request during DATA: master2 raises valid mid-burst -> m_arready_o stays 0 until rlast, then master2 is granted in the following IDLE cycle.
- Reset mid-operation: rst=1 in ADDR with s_arready_i=0 -> next cycle IDLE, s_arvalid_o=0, rr_ptr=0.
- AR_TIMEOUT_EN with TIMEOUT_CYC=16: AR accepted, no R beats -> timeout_o pulses 1 cycle, 16 cycles after DATA entry; busy_o=0 next cycle.
